// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4 -- four-requester round-robin arbiter with hold limit.
//
// Shares one downstream resource between four clients. The winner is found
// by scanning the requests starting at a rotating priority pointer. The grant
// is a registered one-hot decode of the winning index. Every release spends
// exactly one IDLE cycle with gnt=0 before the next grant (bus turnaround).
// A hold counter forces a release after MAX_HOLD consecutive grant cycles.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   en         in   enable; low blocks new grants and releases an active one
//   req[3:0]   in   per-client request, held high while the resource is needed
//   gnt[3:0]   out  registered one-hot grant, 0000 when idle
//   gnt_idx    out  binary index of the granted client (0 when idle)
//   gnt_valid  out  high while a grant is active
//   timeout    out  one-cycle pulse after a forced (hold-limit) release
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    state_t           state_q;
    logic [3:0]       gnt_q;
    logic [1:0]       gnt_idx_q;
    logic             gnt_valid_q;
    logic             timeout_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]       win_idx_d;
    logic             win_found_d;
    logic [1:0]       cand;

    function automatic logic [3:0] decode(input logic [1:0] idx);
        decode = 4'b0001 << idx;
    endfunction

    // Scan from ptr+3 down to ptr so the last hit (highest priority) wins.
    always_comb begin
        win_idx_d   = 2'b00;
        win_found_d = 1'b0;
        cand        = 2'b00;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (req[cand]) begin
                win_idx_d   = cand;
                win_found_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 4'b0000;
            gnt_idx_q   <= 2'b00;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= 2'b00;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (en && win_found_d) begin
                        state_q     <= GRANT;
                        gnt_q       <= decode(win_idx_d);
                        gnt_idx_q   <= win_idx_d;
                        gnt_valid_q <= 1'b1;
                        cnt_q       <= CNT_W'(1);
                    end
                end
                GRANT: begin
                    if (!en || !req[gnt_idx_q] || (cnt_q == HOLD_LIMIT)) begin
                        state_q     <= IDLE;
                        gnt_q       <= 4'b0000;
                        gnt_idx_q   <= 2'b00;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= gnt_idx_q + 2'd1;
                        cnt_q       <= '0;
                        // Reaching this point with en high and req still held
                        // means only the hold limit caused the release.
                        timeout_q   <= en && req[gnt_idx_q];
                    end else begin
                        cnt_q     <= cnt_q + CNT_W'(1);
                        timeout_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the resource, since which cycle, and whose
    // turn it is next, all as plain integers.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_start = 0;
    int cyc     = 0;
    bit m_to    = 1'b0;

    always @(posedge clk) begin
        int w;
        w = -1;
        if (!rst_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_start <= 0;
            m_to    <= 1'b0;
        end else if (m_owner < 0) begin
            m_to <= 1'b0;
            if (en)
                for (int k = 3; k >= 0; k--)
                    if (req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            if (w >= 0) begin
                m_owner <= w;
                m_start <= cyc;
            end
        end else begin
            if (!en || !req[m_owner] || (cyc - m_start) >= MAX_HOLD) begin
                m_to    <= en && req[m_owner];
                m_ptr   <= (m_owner + 1) % 4;
                m_owner <= -1;
            end
        end
        cyc <= cyc + 1;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; req = 4'b1111;
        repeat (3) step();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        checks++; if (gnt_idx !== 2'b00) begin errors++; $display("FAIL reset_idx: got %0d want 0", gnt_idx); end
        rst_n = 1'b1; en = 1'b0;
        repeat (3) step();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL disabled_gnt: got %b want 0000", gnt); end
    endtask

    task automatic test_single();
        req = 4'b0100; en = 1'b1;
        step();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b want 0100", gnt); end
        checks++; if (gnt_idx !== 2'd2) begin errors++; $display("FAIL single_idx: got %0d want 2", gnt_idx); end
        checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", gnt_valid); end
        repeat (2) step();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_hold: got %b want 0100", gnt); end
        req = 4'b0000;
        step();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_release: got %b want 0000", gnt); end
    endtask

    task automatic test_round_robin();
        logic [3:0] e;
        rst_n = 1'b0; req = 4'b0000;
        step();
        rst_n = 1'b1; req = 4'b1111; en = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            e = 4'b0001 << (k % 4);
            for (int h = 0; h < 3; h++) begin
                checks++; if (gnt !== e) begin errors++; $display("FAIL rr_grant%0d_cyc%0d: got %b want %b", k, h, gnt, e); end
                if (h < 2) step();
            end
            if (k == 4) req = 4'b0000;
            else req[k % 4] = 1'b0;
            step();
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_gap%0d: got %b want 0000", k, gnt); end
            if (k < 4) begin
                req[k % 4] = 1'b1;
                step();
            end
        end
    endtask

    task automatic test_priority_wrap();
        req = 4'b1000;
        step();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_c3: got %b want 1000", gnt); end
        req = 4'b0000;
        step();
        req = 4'b1010;
        step();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wrap_1010: got %b want 0010", gnt); end
        req = 4'b0000;
        step();
        req = 4'b1011;
        step();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_1011: got %b want 1000", gnt); end
        checks++; if (gnt_idx !== 2'd3) begin errors++; $display("FAIL wrap_idx: got %0d want 3", gnt_idx); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_timeout();
        req = 4'b0001;
        step();
        for (int i = 0; i < MAX_HOLD; i++) begin
            checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL to_hold%0d: got %b want 0001", i, gnt); end
            checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_early%0d: got %b want 0", i, timeout); end
            step();
        end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL to_release: got %b want 0000", gnt); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", timeout); end
        step();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL to_regrant: got %b want 0001", gnt); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_len: got %b want 0", timeout); end
        repeat (MAX_HOLD) step();
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse2: got %b want 1", timeout); end
        req = 4'b0011;
        step();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL to_fair: got %b want 0010", gnt); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_disable();
        req = 4'b0100; en = 1'b1;
        step();
        repeat (4) step();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL dis_cyc5: got %b want 0100", gnt); end
        en = 1'b0;
        step();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL dis_release: got %b want 0000", gnt); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL dis_timeout: got %b want 0", timeout); end
        en = 1'b1; req = 4'b1101;
        step();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL dis_next: got %b want 1000", gnt); end
    endtask

    task automatic test_reset_mid_grant();
        rst_n = 1'b0;
        step();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL midrst_gnt: got %b want 0000", gnt); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", gnt_valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL midrst_timeout: got %b want 0", timeout); end
        rst_n = 1'b1; req = 4'b0000;
        step();
    endtask

    task automatic test_random();
        logic [3:0] eg;
        logic [1:0] ei;
        for (int c = 0; c < 1500; c++) begin
            step();
            eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
            ei = (m_owner < 0) ? 2'd0 : 2'(m_owner);
            checks++; if (gnt !== eg) begin errors++; $display("FAIL rnd_gnt@%0d: got %b want %b", c, gnt, eg); end
            checks++; if (gnt_idx !== ei) begin errors++; $display("FAIL rnd_idx@%0d: got %0d want %0d", c, gnt_idx, ei); end
            checks++; if (gnt_valid !== (m_owner >= 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", c, gnt_valid, (m_owner >= 0)); end
            checks++; if (timeout !== m_to) begin errors++; $display("FAIL rnd_timeout@%0d: got %b want %b", c, timeout, m_to); end
            rst_n = ($urandom_range(0, 299) != 0);
            en    = ($urandom_range(0, 39) != 0);
            for (int b = 0; b < 4; b++)
                if (b == m_owner) begin
                    if ($urandom_range(0, 39) == 0) req[b] = ~req[b];
                end else begin
                    if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
                end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_priority_wrap();
        test_timeout();
        test_disable();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
